// File: rtl/image_writer_if.sv
// image_writer_if -- bundles the pixel stream, clear request and memory
// write port of image_writer.
//   clear       : single-cycle request to blank the image memory
//   pix_valid   : pix_data / pix_sof valid
//   pix_data    : B&W pixel, 1 = lit
//   pix_sof     : current pixel is the first pixel of a frame
//   pix_ready   : writer accepts a pixel this cycle
//   busy        : clear sweep in progress
//   mem_we      : memory write strobe
//   mem_addr    : memory word address
//   mem_din     : memory write data (bit 15 = leftmost pixel)
//   frame_done  : pulse with the write of the last word of a frame
// slave modport is the writer side, master is the source/memory side.
interface image_writer_if #(
    parameter int ADDR_W = 12
) ();
    logic              clear;
    logic              pix_valid;
    logic              pix_data;
    logic              pix_sof;
    logic              pix_ready;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              frame_done;

    modport slave (
        input  clear, pix_valid, pix_data, pix_sof,
        output pix_ready, busy, mem_we, mem_addr, mem_din, frame_done
    );

    modport master (
        output clear, pix_valid, pix_data, pix_sof,
        input  pix_ready, busy, mem_we, mem_addr, mem_din, frame_done
    );
endinterface

// File: rtl/image_writer.sv
// image_writer -- packs a 1-bit pixel stream into 16-pixel words and writes
// them linearly into an image memory; can blank the whole memory on request
// and always blanks it after reset.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : image_writer_if.slave (pixel stream in, memory write port out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// CLEAR  | sweeping 16'h0000 into addresses 0..DEPTH-1, one per cycle
// STREAM | accepting pixels, writing each completed word
module image_writer #(
    parameter int WORDS_PER_LINE = 1,
    parameter int LINES          = 256,
    parameter int ADDR_W         = 12
) (
    input  logic         clk,
    input  logic         rst,
    image_writer_if.slave bus
);
    localparam int                DEPTH     = WORDS_PER_LINE * LINES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_addr_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [3:0]        pix_cnt_q;
    // Only the first 15 pixels of a word need storing; the 16th goes
    // straight into mem_din with them.
    logic [14:0]       shreg_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_din_q;
    logic              frame_done_q;

    logic              pix_ready_c;
    logic              accept;
    logic              sweep_last;
    logic              word_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_ready_c = 1'b0;
        accept      = 1'b0;
        sweep_last  = (sweep_addr_q == LAST_ADDR);
        word_last   = (word_addr_q == LAST_ADDR);
        case (state_q)
            CLEAR: begin
                if (sweep_last) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // rst gating keeps the stream stalled during a reset that
                // arrives mid-stream, before the state register reacts.
                pix_ready_c = !bus.clear && !rst;
                accept      = bus.pix_valid && pix_ready_c;
                if (bus.clear) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_addr_q <= '0;
            word_addr_q  <= '0;
            pix_cnt_q    <= '0;
            shreg_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    mem_we_q     <= 1'b1;
                    mem_addr_q   <= sweep_addr_q;
                    mem_din_q    <= 16'h0000;
                    sweep_addr_q <= sweep_last ? '0 : sweep_addr_q + 1'b1;
                    word_addr_q  <= '0;
                    pix_cnt_q    <= '0;
                end
                STREAM: begin
                    sweep_addr_q <= '0;
                    if (bus.clear) begin
                        // Partial word is dropped; a completed word was
                        // already registered last cycle and still goes out.
                        word_addr_q <= '0;
                        pix_cnt_q   <= '0;
                    end else if (accept) begin
                        if (bus.pix_sof) begin
                            shreg_q     <= {14'b0, bus.pix_data};
                            pix_cnt_q   <= 4'd1;
                            word_addr_q <= '0;
                        end else if (pix_cnt_q == 4'd15) begin
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= word_addr_q;
                            mem_din_q    <= {shreg_q, bus.pix_data};
                            frame_done_q <= word_last;
                            word_addr_q  <= word_last ? '0 : word_addr_q + 1'b1;
                            pix_cnt_q    <= '0;
                        end else begin
                            shreg_q   <= {shreg_q[13:0], bus.pix_data};
                            pix_cnt_q <= pix_cnt_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pix_ready  = pix_ready_c;
    assign bus.busy       = (state_q == CLEAR) || rst;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_image_writer.sv
// tb_image_writer -- scoreboard bench for image_writer with default
// parameters (1 word per line, 256 lines, 12-bit addresses).
module tb_image_writer;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 256;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       din;
        logic              fd;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  exp_q[$];

    image_writer_if #(.ADDR_W(ADDR_W)) bus ();

    image_writer #(
        .WORDS_PER_LINE(1),
        .LINES(256),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d din=%h, none expected",
                         bus.mem_addr, bus.mem_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_din !== e.din ||
                    bus.frame_done !== e.fd) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d din=%h fd=%b, expected addr=%0d din=%h fd=%b",
                             bus.mem_addr, bus.mem_din, bus.frame_done, e.addr, e.din, e.fd);
                end
            end
        end else if (bus.frame_done === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_done_no_write: frame_done=1 with mem_we=%b, expected mem_we=1",
                     bus.mem_we);
        end
    end

    task automatic push_wr(input int addr, input logic [15:0] din, input logic fd);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.din  = din;
        e.fd   = fd;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int first, input int last);
        for (int i = first; i <= last; i++) push_wr(i, 16'h0000, 1'b0);
    endtask

    task automatic send_pix(input logic d, input logic sof);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        @(posedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input logic sof_first);
        for (int i = 0; i < 16; i++) send_pix(w[15-i], sof_first && (i == 0));
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_not_busy(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
        end
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d writes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_din !== 16'h0 ||
            bus.frame_done !== 1'b0 || bus.busy !== 1'b1 || bus.pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%0d din=%h fd=%b busy=%b rdy=%b, expected 0 0 0000 0 1 0",
                     bus.mem_we, bus.mem_addr, bus.mem_din, bus.frame_done, bus.busy, bus.pix_ready);
        end
        push_sweep(0, DEPTH - 1);
        rst = 1'b0;
        wait_not_busy("reset_sweep", 400);
        @(posedge clk); #1;
        check_drained("reset_sweep");
        n_tests++;
        if (bus.pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: pix_ready=%b, expected 1", bus.pix_ready);
        end
    endtask

    task automatic test_word();
        push_wr(0, 16'h8001, 1'b0);
        send_word(16'h8001, 1'b1);
        #1;
        n_tests++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0 || bus.mem_din !== 16'h8001) begin
            n_fail++;
            $display("FAIL word_latency: we=%b addr=%0d din=%h one cycle after 16th pixel, expected 1 0 8001",
                     bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        idle(2);
        check_drained("word");
    endtask

    task automatic test_frame();
        for (int i = 0; i < DEPTH; i++) push_wr(i, 16'hFFFF, i == DEPTH - 1);
        push_wr(0, 16'hFFFF, 1'b0);
        for (int w = 0; w <= DEPTH; w++) send_word(16'hFFFF, w == 0);
        idle(2);
        check_drained("frame");
    endtask

    task automatic test_sof_discard();
        for (int i = 0; i < 5; i++) send_pix(1'b1, 1'b0);
        push_wr(0, 16'hFFFF, 1'b0);
        send_word(16'hFFFF, 1'b1);
        idle(2);
        check_drained("sof_discard");
    endtask

    task automatic test_sof_boundary();
        push_wr(0, 16'h5A3C, 1'b0);
        send_word(16'h5A3C, 1'b1);
        idle(2);
        check_drained("sof_boundary");
    endtask

    task automatic test_clear_pending();
        push_wr(1, 16'hC3A5, 1'b0);
        push_sweep(0, DEPTH - 1);
        send_word(16'hC3A5, 1'b0);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.clear     = 1'b1;
        #1;
        n_tests++;
        if (bus.pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_pending_ready: pix_ready=%b, expected 0", bus.pix_ready);
        end
        @(negedge clk);
        bus.clear = 1'b0;
        wait_not_busy("clear_pending", 400);
        idle(2);
        check_drained("clear_pending");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) send_pix(1'b1, i == 0);
        push_sweep(0, DEPTH - 1);
        push_wr(0, 16'h8000, 1'b0);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 1'b1;
        bus.pix_sof   = 1'b0;
        bus.clear     = 1'b1;
        #1;
        n_tests++;
        if (bus.pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready: pix_ready=%b with clear=1, expected 0", bus.pix_ready);
        end
        @(negedge clk);
        bus.clear = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_enter: busy=%b pix_ready=%b, expected 1 0", bus.busy, bus.pix_ready);
        end
        repeat (50) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        wait_not_busy("clear_sweep", 400);
        // The held pixel (1) is taken on the next edge as bit 15 of addr 0.
        for (int i = 0; i < 15; i++) send_pix(1'b0, 1'b0);
        idle(2);
        check_drained("clear");
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        push_sweep(0, 100);
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n = 0;
        while (!(bus.mem_we === 1'b1 && bus.mem_addr === ADDR_W'(100)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL midsweep_reach: addr 100 not written within %0d cycles, last addr=%0d",
                     n, bus.mem_addr);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.mem_we !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL midsweep_in_reset: we=%b busy=%b, expected 0 1", bus.mem_we, bus.busy);
            end
        end
        check_drained("midsweep_first");
        push_sweep(0, DEPTH - 1);
        rst = 1'b0;
        wait_not_busy("midsweep_restart", 400);
        idle(2);
        check_drained("midsweep_restart");
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 1'b0;
        bus.pix_sof   = 1'b0;
        test_reset();
        test_word();
        test_frame();
        test_sof_discard();
        test_sof_boundary();
        test_clear_pending();
        test_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/image_writer.md
IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 The block SHALL have parameter WORDS_PER_LINE, default 1, meaning the number of 16-pixel words per image line.
REQ-002 The block SHALL have parameter LINES, default 256, meaning the number of image lines.
REQ-003 The block SHALL have parameter ADDR_W, default 12, meaning the memory address width; DEPTH = WORDS_PER_LINE*LINES SHALL be <= 2^ADDR_W.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; both ports are listed below.
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 clear  in  1  single-cycle request to blank the whole image memory.
REQ-008 pix_valid  in  1  pix_data/pix_sof valid.
REQ-009 pix_data  in  1  B&W pixel, 1 = lit.
REQ-010 pix_sof  in  1  qualifies the current pixel as the first pixel of a frame (x=0, y=0).
REQ-011 pix_ready  out  1  block accepts a pixel this cycle.
REQ-012 busy  out  1  clear sweep in progress.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 mem_addr  out  ADDR_W  memory word address.
REQ-015 mem_din  out  16  memory write data.
REQ-016 frame_done  out  1  one-cycle pulse coincident with the write of the last word of a frame.

Function
REQ-017 The block SHALL implement states CLEAR and STREAM.
REQ-018 A pixel SHALL be accepted only in a cycle where pix_valid and pix_ready are both 1.
REQ-019 pix_ready SHALL be 1 exactly when the state is STREAM and clear is 0; it is combinational.
REQ-020 Packing: the k-th accepted pixel of a word (k = 0..15) SHALL be placed in mem_din[15-k], so bit 15 is the leftmost pixel.
REQ-021 The word address SHALL be y*WORDS_PER_LINE + word index, advancing linearly 0..DEPTH-1.
REQ-022 Timing: in the cycle after the 16th pixel of a word is accepted, the block SHALL drive mem_we=1 for exactly one cycle with that word's mem_addr and mem_din.
REQ-023 Pixel acceptance SHALL continue without stall during the write cycle; sustained one pixel per cycle SHALL be supported.
REQ-024 Completing the word at address DEPTH-1 SHALL pulse frame_done with that write, and the next word SHALL start at address 0 (wrap-around).
REQ-025 An accepted pixel with pix_sof=1 SHALL discard any partial word without writing it, and SHALL become bit 15 of the word at address 0.
REQ-026 When pix_sof=1 arrives exactly on a word boundary, no extra write SHALL occur.
REQ-027 clear=1 in STREAM SHALL discard the partial word, enter CLEAR next cycle, and set busy=1.
REQ-028 In CLEAR the block SHALL write 16'h0000 to addresses 0..DEPTH-1, one per cycle, in ascending order, with mem_we=1 each cycle.
REQ-029 After the DEPTH-1 clear write, the block SHALL enter STREAM with busy=0 and position 0; frame_done SHALL NOT pulse during CLEAR.
REQ-030 clear asserted during CLEAR SHALL be ignored.
REQ-031 A pending word write (REQ-022) in the cycle clear is sampled SHALL still complete before the sweep begins.
REQ-032 mem_addr and mem_din SHALL be registered; when mem_we=0 they hold their last value.

Reset
REQ-033 With rst=1 the block SHALL drive mem_we=0, mem_addr=0, mem_din=0, frame_done=0, busy=1, pix_ready=0, clear the pixel/word counters, and drop the partial word.
REQ-034 After rst deasserts, the block SHALL start a CLEAR sweep from address 0, so the memory is blank before streaming.
REQ-035 rst asserted mid-sweep or mid-word SHALL abort the operation with no further write and restart per REQ-033/034.

Verification
REQ-036 Reset then idle with defaults -> 256 consecutive writes of 0x0000 to addresses 0..255, then busy=0 and pix_ready=1.
REQ-037 Stream 16 pixels 1,0,0,...,0,1 with sof on the first -> one write, addr 0, din 0x8001, one cycle after the 16th accept.
REQ-038 Stream 4096 continuous pixels, all 1, default params -> 256 writes of 0xFFFF, frame_done on the addr-255 write, then the next word goes to addr 0.
REQ-039 Send 5 pixels, then sof with 16 pixels of 1 -> no write of the partial word; addr 0 receives 0xFFFF.
REQ-040 clear pulse while 7 pixels are pending, pix_valid held 1 -> pix_ready=0 that cycle, no partial write, zero sweep 0..255, then streaming resumes at addr 0.
REQ-041 rst asserted at sweep address 100 -> mem_we=0 during reset, then the sweep restarts at address 0.
